// File: rtl/voice_mixer.sv
// Serial voice mixer: accumulates one voice per clock, applies master gain, saturates, and
// presents the sample over valid/ready. Define MIXER_LFSR_DITHER_EN to add LFSR dither before truncation.
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int GAIN_W     = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voices_in,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic                           sample_tick,
    input  logic [GAIN_W-1:0]              master_gain,
    output logic [SAMPLE_W-1:0]            out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           clip,
    output logic                           drop,
    input  logic                           clr_flags
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES);
    localparam int PROD_W = ACC_W + GAIN_W + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, HOLD} state_t;

    state_t state_reg, state_next;

    logic signed [SAMPLE_W-1:0] voice_lane [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] v_snap_reg [NUM_VOICES];
    logic [NUM_VOICES-1:0]      en_snap_reg;
    logic [GAIN_W-1:0]          gain_snap_reg;

    logic signed [ACC_W-1:0]    acc_reg;
    logic [IDX_W-1:0]           idx_reg;

    logic                       start;
    logic                       last_voice;
    logic                       tick_ignored;
    logic signed [SAMPLE_W-1:0] cur_voice;
    logic signed [ACC_W-1:0]    addend;

    logic signed [PROD_W-1:0]   acc_ext;
    logic signed [PROD_W-1:0]   gain_ext;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   prod_round;
    logic signed [PROD_W-1:0]   res;
    logic [PROD_W-SAMPLE_W:0]   res_top;
    logic                       sat_hit;
    logic [SAMPLE_W-1:0]        sat_data;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_lane
            assign voice_lane[gi] = voices_in[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    assign start        = (state_reg == IDLE) && sample_tick;
    assign tick_ignored = (state_reg != IDLE) && sample_tick;
    assign last_voice   = (idx_reg == IDX_W'(NUM_VOICES - 1));

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (sample_tick) state_next = ACCUM;
            ACCUM: if (last_voice)  state_next = SCALE;
            SCALE: state_next = HOLD;
            HOLD:  if (out_ready)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_reg != IDLE);
    end

    // Snapshot is taken only at mix start, so later input changes cannot disturb the mix
    always_ff @(posedge Clk) begin
        if (start) begin
            for (int i = 0; i < NUM_VOICES; i++) v_snap_reg[i] <= voice_lane[i];
            en_snap_reg   <= voice_en;
            gain_snap_reg <= master_gain;
        end
    end

    assign cur_voice = v_snap_reg[idx_reg];
    assign addend    = en_snap_reg[idx_reg]
                     ? {{(ACC_W-SAMPLE_W){cur_voice[SAMPLE_W-1]}}, cur_voice}
                     : '0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc_reg <= '0;
            idx_reg <= '0;
        end else if (start) begin
            acc_reg <= '0;
            idx_reg <= '0;
        end else if (state_reg == ACCUM) begin
            acc_reg <= acc_reg + addend;
            idx_reg <= idx_reg + 1'b1;
        end
    end

`ifdef MIXER_LFSR_DITHER_EN
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                  lfsr_reg <= 16'hACE1;
        else if (state_reg == SCALE) lfsr_reg <= {lfsr_fb, lfsr_reg[15:1]};
    end

    assign prod_round = prod + {{(PROD_W-GAIN_W){1'b0}}, lfsr_reg[GAIN_W-1:0]};
`else
    assign prod_round = prod;
`endif

    assign acc_ext  = {{(PROD_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
    assign gain_ext = {{(PROD_W-GAIN_W){1'b0}}, gain_snap_reg};
    assign prod     = acc_ext * gain_ext;
    assign res      = prod_round >>> GAIN_W;

    // In range only when every bit from the output sign bit upward agrees
    assign res_top  = res[PROD_W-1:SAMPLE_W-1];
    assign sat_hit  = (|res_top) && !(&res_top);
    assign sat_data = sat_hit
                    ? (res[PROD_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}})
                    : res[SAMPLE_W-1:0];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (state_reg == SCALE) begin
            out_data  <= sat_data;
            out_valid <= 1'b1;
        end else if ((state_reg == HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky flags: a new event in the same cycle as clr_flags takes priority
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clip <= 1'b0;
            drop <= 1'b0;
        end else begin
            if ((state_reg == SCALE) && sat_hit) clip <= 1'b1;
            else if (clr_flags)                  clip <= 1'b0;

            if (tick_ignored)    drop <= 1'b1;
            else if (clr_flags)  drop <= 1'b0;
        end
    end

endmodule
